mips_multicycle_controller: RTL and testbench
=============================================

// Module: mips_multicycle_controller
// PURPOSE
//  Sequencing FSM for the multicycle MIPS datapath (shared ALU, unified memory, IR/PC registers).
//  Decodes opcode from the instruction register; drives every datapath enable/mux select per cycle.
//  Stalls on a ready-based memory handshake.
//  Counts retired instructions; traps on illegal opcodes or memory timeout.
// PARAMETERS
//  CNT_W     32   width of retired-instruction counter
//  WAIT_MAX  255  max cycles one memory access may wait for mem_ready before trap (1..2^16-1)
// PORTS
//  clk            in   1      single clock, rising edge
//  reset          in   1      asynchronous, active-high
//  opcode         in   6      IR[31:26], valid from DECODE onward
//  mem_ready      in   1      memory completes the current mem_read/mem_write access this cycle
//  pc_write       out  1      unconditional PC load
//  pc_write_cond  out  1      PC load if ALU zero (datapath ANDs with zero)
//  i_or_d         out  1      memory address: 0=PC, 1=ALUOut
//  mem_read       out  1      memory read request
//  mem_write      out  1      memory write request
//  ir_write       out  1      load instruction register
//  mem_to_reg     out  1      reg write data: 0=ALUOut, 1=MDR
//  reg_dst        out  1      dest reg: 0=rt, 1=rd
//  reg_write      out  1      register file write enable
//  alu_src_a      out  1      ALU A: 0=PC, 1=rs data
//  alu_src_b      out  2      ALU B: 00=rt data, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
//  alu_op         out  2      00=add, 01=sub, 10=funct-decoded (feeds alu_control_unit)
//  pc_source      out  2      00=ALU result, 01=ALUOut, 10=jump target
//  state          out  4      current state encoding (debug)
//  instr_retired  out  CNT_W  retired-instruction count
//  trap           out  1      sticky; set on illegal opcode or memory timeout
//  trap_timeout   out  1      sticky; 1 = trap cause was memory timeout
// BEHAVIOUR
//  States: FETCH=0 DECODE=1 MEM_ADDR=2 MEM_READ=3 MEM_WB=4 MEM_WRITE=5 EXECUTE=6
//   ALU_WB=7 BRANCH=8 ADDI_EXEC=9 ADDI_WB=10 JUMP=11 TRAP=15; unused codes -> FETCH.
//  Reset (async): state=FETCH, instr_retired=0, trap=trap_timeout=0, wait counter=0;
//   while reset high, all strobes (pc_write*, ir_write, mem_*, reg_write) are 0.
//  Per-state outputs (unlisted outputs 0):
//   FETCH: mem_read, src_b=01; ir_write=pc_write=mem_ready (Mealy); -> DECODE on mem_ready.
//   DECODE: src_b=11 (branch target into ALUOut). Opcode dispatch: 000000->EXECUTE,
//    100011/101011->MEM_ADDR, 000100->BRANCH, 001000->ADDI_EXEC, 000010->JUMP, else->TRAP.
//   MEM_ADDR: src_a=1, src_b=10; -> MEM_READ if lw else MEM_WRITE.
//   MEM_READ: mem_read, i_or_d; -> MEM_WB on mem_ready.  MEM_WB: mem_to_reg, reg_write.
//   MEM_WRITE: mem_write, i_or_d; -> FETCH on mem_ready.
//   EXECUTE: src_a=1, alu_op=10.  ALU_WB: reg_dst, reg_write.
//   BRANCH: src_a=1, alu_op=01, pc_source=01, pc_write_cond.
//   ADDI_EXEC: src_a=1, src_b=10.  ADDI_WB: reg_write.  JUMP: pc_source=10, pc_write.
//   TRAP: all strobes 0; held until reset.
//  Latency with mem_ready always 1: beq/j 3, R/sw/addi 4, lw 5 cycles. Each wait cycle adds 1.
//  Memory handshake: request held constant until mem_ready; mem_ready outside access states ignored.
//  Wait counter: clears on entering an access state; increments each cycle mem_ready=0 in it.
//   If it reaches WAIT_MAX with mem_ready still 0 -> TRAP, trap=trap_timeout=1.
//   mem_ready=1 on the WAIT_MAX-th cycle still completes normally.
//  instr_retired +1 on the last cycle of each instruction (MEM_WB, MEM_WRITE w/ ready, ALU_WB,
//   BRANCH, ADDI_WB, JUMP); wraps 2^CNT_W-1 -> 0. Not incremented on trap.
//  Reset mid-instruction: abandons it immediately, no partial retire; restarts at FETCH.
// TESTING
//  mem_ready=1; R-type then addi -> states 0,1,6,7,0,1,9,10; instr_retired=2 after 8 cycles.
//  lw with mem_ready low 3 cycles in MEM_READ -> mem_read/i_or_d held 3 cycles; total 8 cycles.
//  beq -> BRANCH asserts pc_write_cond=1, pc_source=01, alu_op=01; pc_write=0; back to FETCH.
//  opcode 111111 in DECODE -> state 15, trap=1, trap_timeout=0, all strobes 0 for 20 cycles.
//  WAIT_MAX=4, mem_ready stuck 0 in FETCH -> TRAP after 4 cycles, trap_timeout=1, no ir_write.
//  CNT_W=4, 15 instrs retired then j -> instr_retired=0; reset asserted mid-lw -> outputs 0 at once.

Source files
------------

// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the multicycle MIPS sequencer (master) and its datapath (slave).
// The datapath supplies the decoded opcode and memory-ready; the sequencer drives every enable/select.
interface mips_multicycle_controller_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic             mem_ready;
  logic             pc_write;
  logic             pc_write_cond;
  logic             i_or_d;
  logic             mem_read;
  logic             mem_write;
  logic             ir_write;
  logic             mem_to_reg;
  logic             reg_dst;
  logic             reg_write;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [1:0]       alu_op;
  logic [1:0]       pc_source;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_retired;
  logic             trap;
  logic             trap_timeout;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_retired, trap, trap_timeout
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state, instr_retired, trap, trap_timeout
  );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Multicycle MIPS sequencer: per-state datapath controls, ready-based memory stalls,
// retired-instruction counter and sticky trap on illegal opcode or memory timeout.
module mips_multicycle_controller #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 255
) (
  input logic                         clk,
  input logic                         reset,
  mips_multicycle_controller_if.master bus
);
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,  S_DECODE  = 4'd1,  S_MEM_ADDR = 4'd2,  S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,  S_MEM_WRITE = 4'd5, S_EXECUTE = 4'd6,  S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,  S_ADDI_EXEC = 4'd9, S_ADDI_WB = 4'd10, S_JUMP      = 4'd11,
    S_TRAP      = 4'd15
  } state_t;

  localparam logic [5:0]  OP_R    = 6'b000000;
  localparam logic [5:0]  OP_LW   = 6'b100011;
  localparam logic [5:0]  OP_SW   = 6'b101011;
  localparam logic [5:0]  OP_BEQ  = 6'b000100;
  localparam logic [5:0]  OP_ADDI = 6'b001000;
  localparam logic [5:0]  OP_J    = 6'b000010;
  localparam logic [15:0] WAIT_LAST = 16'(WAIT_MAX - 1);

  state_t           r_state, w_next;
  logic [15:0]      r_wait_cnt;
  logic [CNT_W-1:0] r_instr_retired;
  logic             r_trap, r_trap_timeout;

  logic       w_access, w_timeout, w_retire;
  logic       w_pc_write, w_pc_write_cond, w_i_or_d, w_mem_read, w_mem_write, w_ir_write;
  logic       w_mem_to_reg, w_reg_dst, w_reg_write, w_alu_src_a;
  logic [1:0] w_alu_src_b, w_alu_op, w_pc_source;

  assign w_access  = (r_state == S_FETCH) || (r_state == S_MEM_READ) || (r_state == S_MEM_WRITE);
  assign w_timeout = w_access && !bus.mem_ready && (r_wait_cnt == WAIT_LAST);

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_next          = r_state;
    w_retire        = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_i_or_d        = 1'b0;
    w_mem_read      = 1'b0;
    w_mem_write     = 1'b0;
    w_ir_write      = 1'b0;
    w_mem_to_reg    = 1'b0;
    w_reg_dst       = 1'b0;
    w_reg_write     = 1'b0;
    w_alu_src_a     = 1'b0;
    w_alu_src_b     = 2'b00;
    w_alu_op        = 2'b00;
    w_pc_source     = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
        if (bus.mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        w_alu_src_b = 2'b11;
        case (bus.opcode)
          OP_R:         w_next = S_EXECUTE;
          OP_LW, OP_SW: w_next = S_MEM_ADDR;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDI_EXEC;
          OP_J:         w_next = S_JUMP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = (bus.opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        w_mem_read = 1'b1;
        w_i_or_d   = 1'b1;
        if (bus.mem_ready) w_next = S_MEM_WB;
      end
      S_MEM_WB: begin
        w_mem_to_reg = 1'b1;
        w_reg_write  = 1'b1;
        w_retire     = 1'b1;
        w_next       = S_FETCH;
      end
      S_MEM_WRITE: begin
        w_mem_write = 1'b1;
        w_i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          w_retire = 1'b1;
          w_next   = S_FETCH;
        end
      end
      S_EXECUTE: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = 2'b10;
        w_next      = S_ALU_WB;
      end
      S_ALU_WB: begin
        w_reg_dst   = 1'b1;
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_BRANCH: begin
        w_alu_src_a     = 1'b1;
        w_alu_op        = 2'b01;
        w_pc_source     = 2'b01;
        w_pc_write_cond = 1'b1;
        w_retire        = 1'b1;
        w_next          = S_FETCH;
      end
      S_ADDI_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'b10;
        w_next      = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        w_reg_write = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_JUMP: begin
        w_pc_source = 2'b10;
        w_pc_write  = 1'b1;
        w_retire    = 1'b1;
        w_next      = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next   = S_TRAP;
      w_retire = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_FETCH;
      r_wait_cnt      <= '0;
      r_instr_retired <= '0;
      r_trap          <= 1'b0;
      r_trap_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state)                r_wait_cnt <= '0;
      else if (w_access && !bus.mem_ready) r_wait_cnt <= r_wait_cnt + 16'd1;
      if (w_retire) r_instr_retired <= r_instr_retired + CNT_W'(1);
      if (w_next == S_TRAP && r_state != S_TRAP) begin
        r_trap         <= 1'b1;
        r_trap_timeout <= w_timeout;
      end
    end
  end

  // NOTE: FETCH strobes are Mealy on mem_ready, so they are gated by reset to stay quiet while it is held.
  assign bus.pc_write      = w_pc_write      & ~reset;
  assign bus.pc_write_cond = w_pc_write_cond & ~reset;
  assign bus.mem_read      = w_mem_read      & ~reset;
  assign bus.mem_write     = w_mem_write     & ~reset;
  assign bus.ir_write      = w_ir_write      & ~reset;
  assign bus.reg_write     = w_reg_write     & ~reset;
  assign bus.i_or_d        = w_i_or_d;
  assign bus.mem_to_reg    = w_mem_to_reg;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_source     = w_pc_source;
  assign bus.state         = r_state;
  assign bus.instr_retired = r_instr_retired;
  assign bus.trap          = r_trap;
  assign bus.trap_timeout  = r_trap_timeout;
endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Scoreboard bench for the multicycle MIPS sequencer: per-cycle expected state and control
// word are queued as stimulus is driven and popped when the outputs are sampled.
module tb_mips_multicycle_controller;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 4;

  localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEM_ADDR = 4'd2, S_MEM_READ = 4'd3,
                         S_MEM_WB = 4'd4, S_MEM_WRITE = 4'd5, S_EXECUTE = 4'd6, S_ALU_WB = 4'd7,
                         S_BRANCH = 4'd8, S_ADDI_EXEC = 4'd9, S_ADDI_WB = 4'd10, S_JUMP = 4'd11,
                         S_TRAP = 4'd15;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010,
                         OP_BAD = 6'b111111;

  typedef struct {
    logic [3:0]  st;
    logic [15:0] ctrl;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;
  logic [CNT_W-1:0] exp_ret;
  exp_t sb[$];

  mips_multicycle_controller_if #(.CNT_W(CNT_W)) bus ();

  mips_multicycle_controller #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected control word from the state table; bit order matches dut_ctrl().
  function automatic logic [15:0] ctrl_of(input logic [3:0] st, input logic rdy);
    logic pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa;
    logic [1:0] sb_, op, ps;
    {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa} = '0;
    {sb_, op, ps} = '0;
    case (st)
      S_FETCH:     begin mr = 1; sb_ = 2'b01; irw = rdy; pw = rdy; end
      S_DECODE:    sb_ = 2'b11;
      S_MEM_ADDR:  begin sa = 1; sb_ = 2'b10; end
      S_MEM_READ:  begin mr = 1; iod = 1; end
      S_MEM_WB:    begin m2r = 1; rw = 1; end
      S_MEM_WRITE: begin mw = 1; iod = 1; end
      S_EXECUTE:   begin sa = 1; op = 2'b10; end
      S_ALU_WB:    begin rd = 1; rw = 1; end
      S_BRANCH:    begin sa = 1; op = 2'b01; ps = 2'b01; pwc = 1; end
      S_ADDI_EXEC: begin sa = 1; sb_ = 2'b10; end
      S_ADDI_WB:   rw = 1;
      S_JUMP:      begin ps = 2'b10; pw = 1; end
      default:     ;
    endcase
    return {pw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb_, op, ps};
  endfunction

  function automatic logic [15:0] dut_ctrl();
    return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
            bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
            bus.alu_src_b, bus.alu_op, bus.pc_source};
  endfunction

  function automatic logic [5:0] dut_strobes();
    return {bus.pc_write, bus.pc_write_cond, bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_write};
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One clock cycle: entered at a falling edge, returns at the next falling edge.
  task automatic cyc(input logic [5:0] op, input logic rdy, input logic [3:0] st);
    exp_t e;
    bus.opcode    = op;
    bus.mem_ready = rdy;
    sb.push_back('{st: st, ctrl: ctrl_of(st, rdy)});
    #2;
    e = sb.pop_front();
    check("state", 32'(bus.state), 32'(e.st));
    check("ctrl", 32'(dut_ctrl()), 32'(e.ctrl));
    @(negedge clk);
  endtask

  task automatic instr(input logic [5:0] op, input int fw, input int mw);
    bit legal = 1'b1;
    for (int i = 0; i < fw; i++) cyc(op, 1'b0, S_FETCH);
    cyc(op, 1'b1, S_FETCH);
    cyc(op, rnd(), S_DECODE);
    case (op)
      OP_R:    begin cyc(op, rnd(), S_EXECUTE); cyc(op, rnd(), S_ALU_WB); end
      OP_LW: begin
        cyc(op, rnd(), S_MEM_ADDR);
        for (int i = 0; i < mw; i++) cyc(op, 1'b0, S_MEM_READ);
        cyc(op, 1'b1, S_MEM_READ);
        cyc(op, rnd(), S_MEM_WB);
      end
      OP_SW: begin
        cyc(op, rnd(), S_MEM_ADDR);
        for (int i = 0; i < mw; i++) cyc(op, 1'b0, S_MEM_WRITE);
        cyc(op, 1'b1, S_MEM_WRITE);
      end
      OP_BEQ:  cyc(op, rnd(), S_BRANCH);
      OP_ADDI: begin cyc(op, rnd(), S_ADDI_EXEC); cyc(op, rnd(), S_ADDI_WB); end
      OP_J:    cyc(op, rnd(), S_JUMP);
      default: begin
        legal = 1'b0;
        for (int i = 0; i < 20; i++) cyc(op, rnd(), S_TRAP);
        check("trap", 32'(bus.trap), 32'd1);
        check("trap_timeout", 32'(bus.trap_timeout), 32'd0);
      end
    endcase
    if (legal) exp_ret = exp_ret + 1'b1;
    check("retired", 32'(bus.instr_retired), 32'(exp_ret));
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    #1;
    check("rst_strobes", 32'(dut_strobes()), 32'd0);
    check("rst_state", 32'(bus.state), 32'(S_FETCH));
    @(negedge clk);
    check("rst_retired", 32'(bus.instr_retired), 32'd0);
    check("rst_trap", 32'({bus.trap, bus.trap_timeout}), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
  endtask

  initial begin
    logic [5:0] ops [6];
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    n_checks = 0;
    n_errors = 0;
    exp_ret  = '0;
    reset    = 1'b1;
    bus.opcode    = OP_R;
    bus.mem_ready = 1'b1;
    @(negedge clk);
    do_reset();

    instr(OP_R, 0, 0);
    instr(OP_ADDI, 0, 0);
    check("retired_after_8", 32'(bus.instr_retired), 32'd2);
    instr(OP_LW, 0, 3);
    instr(OP_SW, 2, 1);
    instr(OP_BEQ, 0, 0);
    instr(OP_J, 3, 0);

    while (exp_ret != 4'd15) instr(ops[$urandom_range(0, 5)], $urandom_range(0, 3), $urandom_range(0, 3));
    instr(OP_J, 0, 0);
    check("retired_wrap", 32'(bus.instr_retired), 32'd0);
    instr(OP_R, 0, 0);

    cyc(OP_LW, 1'b1, S_FETCH);
    cyc(OP_LW, 1'b1, S_DECODE);
    cyc(OP_LW, 1'b0, S_MEM_ADDR);
    cyc(OP_LW, 1'b0, S_MEM_READ);
    bus.mem_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("midlw_strobes", 32'(dut_strobes()), 32'd0);
    check("midlw_state", 32'(bus.state), 32'(S_FETCH));
    check("midlw_retired", 32'(bus.instr_retired), 32'd0);
    @(negedge clk);
    reset   = 1'b0;
    exp_ret = '0;
    instr(OP_R, 0, 0);

    instr(OP_BAD, 0, 0);

    do_reset();
    for (int i = 0; i < WAIT_MAX; i++) cyc(OP_R, 1'b0, S_FETCH);
    for (int i = 0; i < 3; i++) cyc(OP_R, rnd(), S_TRAP);
    check("to_trap", 32'(bus.trap), 32'd1);
    check("to_timeout", 32'(bus.trap_timeout), 32'd1);
    check("to_retired", 32'(bus.instr_retired), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
